// File: rtl/gate_route_ctrl_pkg.sv
// Shared types and helpers for the gate route-capability controller.
// Holds the control FSM encoding and width helpers used by the top and arbiter.
package gate_route_ctrl_pkg;

  localparam int DEF_N_PORTS = 4;
  localparam int DEF_N_DESTS = 4;
  localparam int DEF_ROUTE_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } gate_ctrl_state_t;

  // Index width that stays at least one bit wide for tiny tables.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gate_route_ctrl_rr_arb.sv
// Round-robin arbiter: first request at or after ptr wins.
// Ports: req (requests), ptr (start port), gnt (one-hot), gnt_idx, gnt_any.
module gate_rr_arb
  import gate_route_ctrl_pkg::*;
#(
  parameter int N  = DEF_N_PORTS,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_any && req[(int'(ptr) + i) % N]) begin
        gnt[(int'(ptr) + i) % N] = 1'b1;
        gnt_idx = PW'((int'(ptr) + i) % N);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gate_route_ctrl.sv
// Route-capability table shared between host writes and N_PORTS lookups.
// Ports: aclk/areset, cap_wr_* host channel, flush_req/busy, lkp_req_*/lkp_rsp_*.
module gate_route_ctrl
  import gate_route_ctrl_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int N_DESTS = DEF_N_DESTS,
  parameter int ROUTE_W = DEF_ROUTE_W,
  parameter int IDX_W   = idx_w(N_DESTS),
  parameter int PORT_W  = idx_w(N_PORTS)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cap_wr_valid,
  output logic                     cap_wr_ready,
  input  logic [IDX_W-1:0]         cap_wr_idx,
  input  logic [ROUTE_W-1:0]       cap_wr_route,
  input  logic                     cap_wr_revoke,
  input  logic                     flush_req,
  output logic                     flush_busy,
  input  logic [N_PORTS-1:0]       lkp_req_valid,
  output logic [N_PORTS-1:0]       lkp_req_ready,
  input  logic [N_PORTS*IDX_W-1:0] lkp_req_idx,
  output logic                     lkp_rsp_valid,
  output logic [PORT_W-1:0]        lkp_rsp_port,
  output logic                     lkp_rsp_hit,
  output logic [ROUTE_W-1:0]       lkp_rsp_route
);

  typedef struct packed {
    logic               valid;
    logic [PORT_W-1:0]  port;
    logic               hit;
    logic [ROUTE_W-1:0] route;
  } rsp_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_DESTS - 1);
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(N_PORTS - 1);

  gate_ctrl_state_t state_q, state_d;
  logic [IDX_W-1:0] fcnt_q, fcnt_d;
  logic [PORT_W-1:0] ptr_q;
  logic [N_DESTS-1:0] valid_q;
  logic [ROUTE_W-1:0] route_q [N_DESTS];
  rsp_t rsp_q;

  logic [N_PORTS-1:0] arb_gnt;
  logic [PORT_W-1:0] arb_idx;
  logic arb_any;
  logic idle, wr_acc, lkp_acc;
  logic [IDX_W-1:0] sel_idx;
  logic sel_hit;
  logic [ROUTE_W-1:0] sel_route;

  gate_rr_arb #(
    .N  (N_PORTS),
    .PW (PORT_W)
  ) u_arb (
    .req     (lkp_req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        fcnt_d = '0;
        if (flush_req) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == LAST_IDX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks
  // from the pre-reset state during the reset cycle.
  always_comb begin
    idle          = (state_q == ST_IDLE) && !areset;
    flush_busy    = (state_q == ST_FLUSH) && !areset;
    cap_wr_ready  = idle && !flush_req;
    lkp_req_ready = idle ? arb_gnt : '0;
    wr_acc        = cap_wr_valid && cap_wr_ready;
    lkp_acc       = idle && arb_any;
  end

  // Compare-per-entry select keeps out-of-range indices a clean miss.
  always_comb begin
    sel_idx   = lkp_req_idx[int'(arb_idx)*IDX_W +: IDX_W];
    sel_hit   = 1'b0;
    sel_route = '0;
    for (int d = 0; d < N_DESTS; d++) begin
      if (sel_idx == IDX_W'(d)) begin
        sel_hit   = valid_q[d];
        sel_route = valid_q[d] ? route_q[d] : '0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      valid_q <= '0;
      for (int d = 0; d < N_DESTS; d++) route_q[d] <= '0;
    end else begin
      for (int d = 0; d < N_DESTS; d++) begin
        if (flush_busy && fcnt_q == IDX_W'(d))
          valid_q[d] <= 1'b0;
        if (wr_acc && cap_wr_idx == IDX_W'(d)) begin
          valid_q[d] <= !cap_wr_revoke;
          route_q[d] <= cap_wr_revoke ? '0 : cap_wr_route;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rsp_q <= '0;
      ptr_q <= '0;
    end else begin
      rsp_q.valid <= lkp_acc;
      if (lkp_acc) begin
        rsp_q.port  <= arb_idx;
        rsp_q.hit   <= sel_hit;
        rsp_q.route <= sel_route;
        ptr_q <= (arb_idx == LAST_PORT) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  assign lkp_rsp_valid = rsp_q.valid;
  assign lkp_rsp_port  = rsp_q.port;
  assign lkp_rsp_hit   = rsp_q.hit;
  assign lkp_rsp_route = rsp_q.route;

endmodule

// File: tb/tb_gate_route_ctrl.sv
// Bench for gate_route_ctrl: vector table, flush/reset sequences, random run.
// A table-level reference model checks every cycle.
module tb_gate_route_ctrl;

  localparam int NP = 4;
  localparam int ND = 4;
  localparam int RW = 8;
  localparam int IW = 3;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic           areset;
  logic           cap_wr_valid;
  logic           cap_wr_ready;
  logic [IW-1:0]  cap_wr_idx;
  logic [RW-1:0]  cap_wr_route;
  logic           cap_wr_revoke;
  logic           flush_req;
  logic           flush_busy;
  logic [NP-1:0]  lkp_req_valid;
  logic [NP-1:0]  lkp_req_ready;
  logic [NP*IW-1:0] lkp_req_idx;
  logic           lkp_rsp_valid;
  logic [1:0]     lkp_rsp_port;
  logic           lkp_rsp_hit;
  logic [RW-1:0]  lkp_rsp_route;

  gate_route_ctrl #(
    .N_PORTS (NP),
    .N_DESTS (ND),
    .ROUTE_W (RW),
    .IDX_W   (IW),
    .PORT_W  (2)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cap_wr_valid  (cap_wr_valid),
    .cap_wr_ready  (cap_wr_ready),
    .cap_wr_idx    (cap_wr_idx),
    .cap_wr_route  (cap_wr_route),
    .cap_wr_revoke (cap_wr_revoke),
    .flush_req     (flush_req),
    .flush_busy    (flush_busy),
    .lkp_req_valid (lkp_req_valid),
    .lkp_req_ready (lkp_req_ready),
    .lkp_req_idx   (lkp_req_idx),
    .lkp_rsp_valid (lkp_rsp_valid),
    .lkp_rsp_port  (lkp_rsp_port),
    .lkp_rsp_hit   (lkp_rsp_hit),
    .lkp_rsp_route (lkp_rsp_route)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: table contents, RR pointer, flush cycles left.
  bit         mv [ND];
  logic [7:0] mr [ND];
  int         mptr;
  int         mflush;

  logic       e_wrdy, e_busy, e_rv, e_hit, was_rst;
  logic [3:0] e_lrdy;
  logic [1:0] e_port;
  logic [7:0] e_route;
  int         e_g;

  logic       s_wrdy, s_busy, s_rv, s_hit;
  logic [3:0] s_lrdy;
  logic [1:0] s_port;
  logic [7:0] s_route;

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      mv[d] = 1'b0;
      mr[d] = 8'h00;
    end
    mptr = 0;
    mflush = 0;
  endtask

  task automatic cycle();
    int idx;
    #1;
    e_g = -1;
    e_lrdy = 4'b0;
    e_wrdy = 1'b0;
    e_busy = 1'b0;
    if (!areset) begin
      e_busy = (mflush > 0);
      e_wrdy = !e_busy && !flush_req;
      if (!e_busy)
        for (int k = 0; k < NP; k++)
          if (e_g < 0 && lkp_req_valid[(mptr + k) % NP])
            e_g = (mptr + k) % NP;
      if (e_g >= 0) e_lrdy = 4'(1 << e_g);
    end
    s_wrdy = cap_wr_ready;
    s_lrdy = lkp_req_ready;
    s_busy = flush_busy;
    chk("cap_wr_ready", 32'(s_wrdy), 32'(e_wrdy));
    chk("lkp_req_ready", 32'(s_lrdy), 32'(e_lrdy));
    chk("flush_busy", 32'(s_busy), 32'(e_busy));

    e_rv = 1'b0;
    e_port = 2'd0;
    e_hit = 1'b0;
    e_route = 8'h00;
    if (areset) begin
      model_clear();
    end else begin
      if (e_g >= 0) begin
        idx = int'(lkp_req_idx[e_g*IW +: IW]);
        e_rv = 1'b1;
        e_port = 2'(e_g);
        if (idx < ND) e_hit = mv[idx];
        if (e_hit) e_route = mr[idx];
        mptr = (e_g + 1) % NP;
      end
      if (e_busy) begin
        mv[ND - mflush] = 1'b0;
        mflush--;
      end else if (flush_req) begin
        mflush = ND;
      end
      if (e_wrdy && cap_wr_valid && cap_wr_idx < ND) begin
        mv[cap_wr_idx] = !cap_wr_revoke;
        mr[cap_wr_idx] = cap_wr_revoke ? 8'h00 : cap_wr_route;
      end
    end
    was_rst = areset;

    @(posedge aclk);
    #1;
    s_rv = lkp_rsp_valid;
    s_port = lkp_rsp_port;
    s_hit = lkp_rsp_hit;
    s_route = lkp_rsp_route;
    chk("rsp_valid", 32'(s_rv), 32'(e_rv));
    if (e_rv || was_rst) begin
      chk("rsp_port", 32'(s_port), 32'(e_port));
      chk("rsp_hit", 32'(s_hit), 32'(e_hit));
      chk("rsp_route", 32'(s_route), 32'(e_route));
    end
    @(negedge aclk);
  endtask

  task automatic set_in(input logic wv, input logic [2:0] wi,
                        input logic [7:0] wr, input logic rev,
                        input logic fl, input logic [3:0] lv,
                        input logic [11:0] li);
    cap_wr_valid = wv;
    cap_wr_idx = wi;
    cap_wr_route = wr;
    cap_wr_revoke = rev;
    flush_req = fl;
    lkp_req_valid = lv;
    lkp_req_idx = li;
  endtask

  typedef struct {
    logic       wv;
    logic [2:0] wi;
    logic [7:0] wr;
    logic       rev;
    logic       fl;
    logic [3:0] lv;
    logic [11:0] li;
    logic [3:0] e_rdy;
    logic       e_rv;
    logic [1:0] e_port;
    logic       e_hit;
    logic [7:0] e_route;
  } vec_t;

  vec_t tv [17];
  int   bc;

  initial begin
    tv[0]  = '{1'b1, 3'd2, 8'hA5, 1'b0, 1'b0, 4'b0000, 12'h000,
               4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b0010, 12'h010,
               4'b0010, 1'b1, 2'd1, 1'b1, 8'hA5};
    tv[2]  = '{1'b1, 3'd1, 8'h11, 1'b0, 1'b0, 4'b0000, 12'h000,
               4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[3]  = '{1'b1, 3'd1, 8'h3C, 1'b0, 1'b0, 4'b0001, 12'h001,
               4'b0001, 1'b1, 2'd0, 1'b1, 8'h11};
    tv[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b0001, 12'h001,
               4'b0001, 1'b1, 2'd0, 1'b1, 8'h3C};
    tv[5]  = '{1'b1, 3'd3, 8'h77, 1'b0, 1'b0, 4'b0000, 12'h000,
               4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[6]  = '{1'b1, 3'd3, 8'hFF, 1'b1, 1'b0, 4'b0000, 12'h000,
               4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tv[7]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b0100, 12'h0C0,
               4'b0100, 1'b1, 2'd2, 1'b0, 8'h00};
    tv[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b1000, 12'hA00,
               4'b1000, 1'b1, 2'd3, 1'b0, 8'h00};
    tv[9]  = '{1'b1, 3'd6, 8'h99, 1'b0, 1'b0, 4'b0001, 12'h006,
               4'b0001, 1'b1, 2'd0, 1'b0, 8'h00};
    tv[10] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b0100, 12'h080,
               4'b0100, 1'b1, 2'd2, 1'b1, 8'hA5};
    tv[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b1000, 12'h000,
               4'b1000, 1'b1, 2'd3, 1'b0, 8'h00};
    tv[12] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b1111, 12'h688,
               4'b0001, 1'b1, 2'd0, 1'b0, 8'h00};
    tv[13] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b1111, 12'h688,
               4'b0010, 1'b1, 2'd1, 1'b1, 8'h3C};
    tv[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b1111, 12'h688,
               4'b0100, 1'b1, 2'd2, 1'b1, 8'hA5};
    tv[15] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b1111, 12'h688,
               4'b1000, 1'b1, 2'd3, 1'b0, 8'h00};
    tv[16] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 4'b1111, 12'h688,
               4'b0001, 1'b1, 2'd0, 1'b0, 8'h00};

    model_clear();
    areset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge aclk);
    cycle();
    cycle();
    areset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_in(tv[i].wv, tv[i].wi, tv[i].wr, tv[i].rev, tv[i].fl,
             tv[i].lv, tv[i].li);
      cycle();
      chk("tv_ready", 32'(s_lrdy), 32'(tv[i].e_rdy));
      chk("tv_rsp_valid", 32'(s_rv), 32'(tv[i].e_rv));
      if (tv[i].e_rv) begin
        chk("tv_rsp_port", 32'(s_port), 32'(tv[i].e_port));
        chk("tv_rsp_hit", 32'(s_hit), 32'(tv[i].e_hit));
        chk("tv_rsp_route", 32'(s_route), 32'(tv[i].e_route));
      end
    end

    for (int e = 0; e < ND; e++) begin
      set_in(1, 3'(e), 8'(8'h10 + e), 0, 0, 0, 0);
      cycle();
    end
    set_in(1, 3'd0, 8'h42, 0, 1, 4'b0001, 12'h001);
    cycle();
    chk("flush_wr_blocked", 32'(s_wrdy), 32'd0);
    chk("inflight_rsp_valid", 32'(s_rv), 32'd1);
    chk("inflight_rsp_route", 32'(s_route), 32'h11);
    set_in(0, 0, 0, 0, 0, 4'b1111, 12'h688);
    bc = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (s_busy) begin
        bc++;
        chk("flush_no_ready", 32'({s_wrdy, s_lrdy}), 32'd0);
      end
    end
    chk("flush_len", 32'(bc), 32'd4);
    for (int e = 0; e < ND; e++) begin
      set_in(0, 0, 0, 0, 0, 4'b0001, 12'(e));
      cycle();
      chk("post_flush_hit", 32'(s_hit), 32'd0);
      chk("post_flush_route", 32'(s_route), 32'd0);
    end

    for (int e = 0; e < ND; e++) begin
      set_in(1, 3'(e), 8'(8'h50 + e), 0, 0, 0, 0);
      cycle();
    end
    set_in(0, 0, 0, 0, 1, 0, 0);
    cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle();
    areset = 1'b1;
    cycle();
    chk("rst_rsp_valid", 32'(s_rv), 32'd0);
    areset = 1'b0;
    cycle();
    chk("rst_flush_busy", 32'(s_busy), 32'd0);
    chk("rst_wr_ready", 32'(s_wrdy), 32'd1);
    for (int e = 0; e < ND; e++) begin
      set_in(0, 0, 0, 0, 0, 4'b0100, 12'(e << 6));
      cycle();
      chk("post_rst_hit", 32'(s_hit), 32'd0);
    end

    for (int r = 0; r < 600; r++) begin
      areset = ($urandom_range(0, 99) == 0);
      set_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             8'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 29) == 0), 4'($urandom),
             12'($urandom));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
